// File: rtl/fetch_pc.sv
// Fetch program counter: branch/jump resolution, exception entry/return,
// and a one-entry buffer holding a redirect that arrived during a stall.
module fetch_pc #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_4180),
  parameter bit               DELAY_SLOT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       br_type,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [15:0]      imm16,
  input  logic [25:0]      idx26,
  input  logic [WIDTH-1:0] pc4_d,
  input  logic             exc_req,
  input  logic             eret,
  output logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc4,
  output logic             redirect,
  output logic             link_we,
  output logic [WIDTH-1:0] link_val,
  output logic             pend_valid
);

  localparam logic [2:0] BR_NONE   = 3'd0;
  localparam logic [2:0] BR_BEQ    = 3'd1;
  localparam logic [2:0] BR_BNE    = 3'd2;
  localparam logic [2:0] BR_BGEZ   = 3'd3;
  localparam logic [2:0] BR_BGEZAL = 3'd4;
  localparam logic [2:0] BR_J      = 3'd5;
  localparam logic [2:0] BR_JAL    = 3'd6;
  localparam logic [2:0] BR_JR     = 3'd7;

  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] epc_d;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] tgt_d;

  logic             taken;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] b_tgt;
  logic [WIDTH-1:0] j_tgt;

  assign b_tgt      = pc4_d + {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
  assign j_tgt      = {pc4_d[WIDTH-1:28], idx26, 2'b00};
  assign pc4        = pc + FOUR;
  assign redirect   = taken;
  assign pend_valid = (state_q == PEND);

  // Branch condition evaluation, target select and link generation
  always_comb begin
    taken    = 1'b0;
    target   = b_tgt;
    link_we  = 1'b0;
    link_val = DELAY_SLOT ? (pc4_d + FOUR) : pc4_d;
    case (br_type)
      BR_NONE:   taken = 1'b0;
      BR_BEQ:    taken = (rs_val == rt_val);
      BR_BNE:    taken = (rs_val != rt_val);
      BR_BGEZ:   taken = ~rs_val[WIDTH-1];
      BR_BGEZAL: begin
        taken   = ~rs_val[WIDTH-1];
        link_we = 1'b1;
      end
      BR_J: begin
        taken  = 1'b1;
        target = j_tgt;
      end
      BR_JAL: begin
        taken   = 1'b1;
        target  = j_tgt;
        link_we = 1'b1;
      end
      BR_JR: begin
        taken  = 1'b1;
        target = rs_val;
      end
      default: taken = 1'b0;
    endcase
  end

  // Next PC / EPC / pending-target selection in priority order
  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    epc_d   = epc;
    tgt_d   = tgt_q;
    if (exc_req) begin
      pc_d    = EXC_VECTOR;
      epc_d   = pc;
      state_d = RUN;
    end else if (eret) begin
      pc_d    = epc;
      state_d = RUN;
    end else if (stall) begin
      // Latest taken redirect seen during the stall wins
      if (taken) begin
        tgt_d   = target;
        state_d = PEND;
      end
    end else if (state_q == PEND) begin
      // A redirect arriving together with the pending load is dropped
      pc_d    = tgt_q;
      state_d = RUN;
    end else if (taken) begin
      pc_d = target;
    end else begin
      pc_d = pc4;
    end
  end

  // State, PC, EPC and pending-target registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc      <= RESET_PC;
      epc     <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
      epc     <= epc_d;
      tgt_q   <= tgt_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc.sv
// Randomized scoreboard bench for fetch_pc against a spec-level PC model.
module tb_fetch_pc;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_V  = 32'h0000_4180;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [2:0]  br_type;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [15:0] imm16;
  logic [25:0] idx26;
  logic [31:0] pc4_d;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        redirect;
  logic        link_we;
  logic [31:0] link_val;
  logic        pend_valid;

  fetch_pc #(
    .WIDTH(32),
    .RESET_PC(RST_PC),
    .EXC_VECTOR(EXC_V),
    .DELAY_SLOT(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_type(br_type),
    .rs_val(rs_val), .rt_val(rt_val), .imm16(imm16), .idx26(idx26),
    .pc4_d(pc4_d), .exc_req(exc_req), .eret(eret), .epc(epc),
    .pc(pc), .pc4(pc4), .redirect(redirect), .link_we(link_we),
    .link_val(link_val), .pend_valid(pend_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] pc4;
    logic [31:0] lv;
    logic        pend;
    logic        rd;
    logic        lw;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   seq_id = 0;

  // Reference model state: architectural PC, EPC, and the held redirect
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  bit          m_pend;
  logic [31:0] m_tgt;

  function automatic void chk(string nm, int id, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s id=%0d actual=%h required=%h t=%0t", nm, id, act, expv, $time);
    end
  endfunction

  // Drive one cycle of inputs and push the spec-derived expectation
  task automatic apply(input bit st, input logic [2:0] bt, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] imm,
                       input logic [25:0] idx, input logic [31:0] p4,
                       input bit exc, input bit er);
    exp_t        e;
    bit          tk;
    logic [31:0] tgt;
    int          off;
    stall = st; br_type = bt; rs_val = rs; rt_val = rt; imm16 = imm;
    idx26 = idx; pc4_d = p4; exc_req = exc; eret = er;
    case (bt)
      3'd1:       tk = (rs == rt);
      3'd2:       tk = (rs != rt);
      3'd3, 3'd4: tk = ($signed(rs) >= 0);
      3'd5, 3'd6, 3'd7: tk = 1'b1;
      default:    tk = 1'b0;
    endcase
    off = int'($signed(imm)) * 4;
    if (bt == 3'd5 || bt == 3'd6) tgt = (p4 & 32'hF000_0000) | (32'(idx) * 4);
    else if (bt == 3'd7)          tgt = rs;
    else                          tgt = p4 + 32'(off);
    e.id = seq_id++;
    e.rd = tk;
    e.lw = (bt == 3'd4 || bt == 3'd6);
    e.lv = p4;
    if (exc) begin
      m_epc = m_pc; m_pc = EXC_V; m_pend = 0;
    end else if (er) begin
      m_pc = m_epc; m_pend = 0;
    end else if (st) begin
      if (tk) begin m_pend = 1; m_tgt = tgt; end
    end else if (m_pend) begin
      m_pc = m_tgt; m_pend = 0;
    end else if (tk) begin
      m_pc = tgt;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    e.pc = m_pc; e.epc = m_epc; e.pend = m_pend; e.pc4 = m_pc + 32'd4;
    q.push_back(e);
  endtask

  task automatic cyc(input bit st, input logic [2:0] bt, input logic [31:0] rs,
                     input logic [31:0] rt, input logic [15:0] imm,
                     input logic [25:0] idx, input logic [31:0] p4,
                     input bit exc, input bit er);
    @(negedge clk);
    apply(st, bt, rs, rt, imm, idx, p4, exc, er);
  endtask

  task automatic idle();
    cyc(0, 3'd0, 0, 0, 0, 0, m_pc + 32'd4, 0, 0);
  endtask

  // Asynchronous reset pulse between clock edges, checked before the next edge
  task automatic reset_pulse();
    @(negedge clk);
    stall = 0; br_type = 0; rs_val = 0; rt_val = 0; imm16 = 0; idx26 = 0;
    pc4_d = 0; exc_req = 0; eret = 0;
    reset = 1'b1;
    #1;
    chk("rst_pc", -1, pc, RST_PC);
    chk("rst_epc", -1, epc, 32'd0);
    chk("rst_pend", -1, 32'(pend_valid), 32'd0);
    chk("rst_pc4", -1, pc4, RST_PC + 32'd4);
    reset = 1'b0;
    #1;
    m_pc = RST_PC; m_epc = 0; m_pend = 0; m_tgt = 0;
    apply(0, 3'd0, 0, 0, 0, 0, RST_PC + 32'd4, 0, 0);
  endtask

  // Monitor: one expectation retires one cycle after each active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", e.id, pc, e.pc);
        chk("epc", e.id, epc, e.epc);
        chk("pend_valid", e.id, 32'(pend_valid), 32'(e.pend));
        chk("pc4", e.id, pc4, e.pc4);
        chk("redirect", e.id, 32'(redirect), 32'(e.rd));
        chk("link_we", e.id, 32'(link_we), 32'(e.lw));
        if (e.lw) chk("link_val", e.id, link_val, e.lv);
      end
    end
  end

  initial begin
    bit          st, ex, er;
    logic [2:0]  bt;
    logic [31:0] rs, rt, p4;
    int          drain;
    reset = 1'b1;
    stall = 0; br_type = 0; rs_val = 0; rt_val = 0; imm16 = 0; idx26 = 0;
    pc4_d = 0; exc_req = 0; eret = 0;
    m_pc = RST_PC; m_epc = 0; m_pend = 0; m_tgt = 0;
    repeat (2) @(posedge clk);
    reset_pulse();
    // Idle fetch sequence from reset
    idle(); idle(); idle();
    // beq taken backwards, then bne with equal operands falls through
    cyc(0, 3'd1, 32'd5, 32'd5, 16'hFFFE, 0, 32'h3008, 0, 0);
    cyc(0, 3'd2, 32'd5, 32'd5, 16'hFFFE, 0, 32'h3008, 0, 0);
    // jal link value and jump target
    cyc(0, 3'd6, 0, 0, 0, 26'h0000C10, 32'h3010, 0, 0);
    // jr during stall, held through two more stall cycles, then released
    cyc(1, 3'd7, 32'h3100, 0, 0, 0, 0, 0, 0);
    cyc(1, 3'd0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 3'd0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
    // Latest-wins overwrite, and a branch colliding with the pending load
    cyc(1, 3'd7, 32'h3200, 0, 0, 0, 0, 0, 0);
    cyc(1, 3'd5, 0, 0, 0, 26'h0000D00, 32'h3000, 0, 0);
    cyc(0, 3'd7, 32'h5000, 0, 0, 0, 0, 0, 0);
    // Jump to 0x3020, build a pending target, take an exception, return
    cyc(0, 3'd5, 0, 0, 0, 26'h0000C08, 32'h3000, 0, 0);
    cyc(1, 3'd7, 32'h3300, 0, 0, 0, 0, 0, 0);
    cyc(1, 3'd0, 0, 0, 0, 0, 0, 1, 1);
    idle(); idle();
    cyc(0, 3'd0, 0, 0, 0, 0, 0, 0, 1);
    // Reset while a target is pending
    cyc(1, 3'd7, 32'h3400, 0, 0, 0, 0, 0, 0);
    reset_pulse();
    // PC wraps past the top of the address space
    cyc(0, 3'd7, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
    idle(); idle();
    // bgezal not taken still links; bgez on negative
    cyc(0, 3'd4, 32'h8000_0000, 0, 16'h0010, 0, 32'h3100, 0, 0);
    cyc(0, 3'd3, 32'h8000_0000, 0, 16'h0010, 0, 32'h3100, 0, 0);
    cyc(0, 3'd4, 32'h0000_0001, 0, 16'h0010, 0, 32'h3100, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 99) < 35);
      ex = ($urandom_range(0, 99) < 3);
      er = ($urandom_range(0, 99) < 4);
      bt = 3'($urandom_range(0, 7));
      rs = $urandom();
      rt = ($urandom_range(0, 1) == 1) ? rs : $urandom();
      p4 = ($urandom_range(0, 3) == 0) ? $urandom() : m_pc + 32'd4;
      if ($urandom_range(0, 99) == 0) reset_pulse();
      else cyc(st, bt, rs, rt, 16'($urandom()), 26'($urandom()), p4, ex, er);
    end
    idle();
    drain = 0;
    while (q.size() > 0 && drain < 20) begin
      @(posedge clk);
      drain++;
    end
    #2;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning PC/data width (>=32).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning PC value after reset.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'h0000_4180, meaning exception entry address.
REQ-004 SHALL have parameter DELAY_SLOT, default 0, meaning link = pc4_d+4 when 1, pc4_d when 0.
REQ-005 SHALL have ports: clk in 1 clock; reset in 1 reset (asynchronous, active-high).
REQ-006 SHALL have ports: stall in 1 hold PC; br_type in 3 (0 none, 1 beq, 2 bne, 3 bgez, 4 bgezal, 5 j, 6 jal, 7 jr).
REQ-007 SHALL have ports: rs_val in WIDTH; rt_val in WIDTH; imm16 in 16; idx26 in 26; pc4_d in WIDTH (PC+4 of decoding instruction).
REQ-008 SHALL have ports: exc_req in 1; eret in 1; epc out WIDTH (saved return PC).
REQ-009 SHALL have ports: pc out WIDTH (current fetch PC); pc4 out WIDTH (pc+4); redirect out 1 (branch/jump taken this cycle); link_we out 1; link_val out WIDTH; pend_valid out 1.

Function
REQ-010 SHALL compute b_tgt = pc4_d + (sign-extended imm16 << 2), truncated to WIDTH.
REQ-011 SHALL compute j_tgt = {pc4_d[WIDTH-1:28], idx26, 2'b00}; jr target = rs_val.
REQ-012 SHALL decide taken combinationally: beq rs==rt; bne rs!=rt; bgez/bgezal rs>=0 (signed); j/jal/jr always.
REQ-013 SHALL drive redirect = taken, independent of stall.
REQ-014 SHALL drive link_we = 1 for jal and for bgezal (taken or not); link_val per DELAY_SLOT.
REQ-015 SHALL drive pc4 = pc + 4 combinationally.
REQ-016 SHALL update pc on each rising clk by priority: exc_req -> EXC_VECTOR; else eret -> epc; else stall -> hold; else pend_valid -> pending target; else taken -> target; else pc4.
REQ-017 SHALL on exc_req capture epc <= pc in the same edge; eret with exc_req set SHALL be ignored.
REQ-018 SHALL, when taken && stall && !exc_req && !eret, set pend_valid=1 and store target (one-entry buffer).
REQ-019 SHALL, while pend_valid=1 and stall=1, overwrite the pending target if a new taken branch arrives (latest wins).
REQ-020 SHALL clear pend_valid on the edge where stall=0 and the pending target is loaded into pc.
REQ-021 SHALL clear pend_valid on exc_req or eret, discarding the pending target.
REQ-022 SHALL ignore a taken branch arriving in the same cycle as a pending-target load (pending wins).
REQ-023 SHALL wrap pc modulo 2^WIDTH without flagging.
REQ-024 SHALL hold pc in states: RUN (pend_valid=0) and PEND (pend_valid=1); RUN->PEND on REQ-018, PEND->RUN on REQ-020/021.

Reset
REQ-025 SHALL on reset assertion immediately (without clk) set pc=RESET_PC, epc=0, pend_valid=0.
REQ-026 SHALL, with reset asserted mid-stall or in PEND, discard pending target; first post-reset fetch PC = RESET_PC.
REQ-027 SHALL keep combinational outputs (redirect, link_we, link_val, pc4) valid functions of inputs during reset.

Verification
REQ-028 Reset then 3 idle clocks -> pc = 0x3000, 0x3004, 0x3008, 0x300C.
REQ-029 beq, rs=rt=5, pc4_d=0x3008, imm16=0xFFFE -> redirect=1, next pc=0x3000; bne same -> pc+4.
REQ-030 jal, pc4_d=0x3010, idx26=0x0000C10 -> pc=0x3040, link_we=1, link_val=0x3010 (0x3014 with DELAY_SLOT=1).
REQ-031 stall=1 with jr rs=0x3100 for 1 cycle, stall held 2 more cycles -> pc held, pend_valid=1; stall drops -> pc=0x3100, pend_valid=0.
REQ-032 exc_req at pc=0x3020 with stall=1 and pend_valid=1 -> pc=0x4180, epc=0x3020, pend_valid=0; later eret -> pc=0x3020.
REQ-033 Async reset pulse between clk edges in PEND -> pc=0x3000 and pend_valid=0 before next edge.
